ysyx_22050710_axil_sram: RTL and testbench

YSYX_22050710_AXIL_SRAM -- requirements
Module: ysyx_22050710_axil_sram

---
 rtl/ysyx_22050710_axil_sram.sv | 224 ++++++++++++++++++++++
 tb/tb_ysyx_22050710_axil_sram.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050710_axil_sram.sv
// rtl/ysyx_22050710_axil_sram.sv - AXI4-Lite SRAM responder with independent read/write FSMs
// Responses arrive LATENCY+1 cycles after the address (and, for writes, data) are accepted.
module ysyx_22050710_axil_sram #(
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_araddr,
    input  logic        i_arvalid,
    output logic        o_arready,
    output logic [63:0] o_rdata,
    output logic [1:0]  o_rresp,
    output logic        o_rvalid,
    input  logic        i_rready,
    input  logic [63:0] i_awaddr,
    input  logic        i_awvalid,
    output logic        o_awready,
    input  logic [63:0] i_wdata,
    input  logic [7:0]  i_wstrb,
    input  logic        i_wvalid,
    output logic        o_wready,
    output logic [1:0]  o_bresp,
    output logic        o_bvalid,
    input  logic        i_bready
);

    localparam int          IW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] SPAN        = 64'(DEPTH) << 3;
    localparam logic [3:0]  LAT         = 4'(LATENCY);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

    function automatic logic in_range(input logic [63:0] addr);
        return (addr >= BASE_ADDR) && ((addr - BASE_ADDR) < SPAN);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [63:0] addr);
        return IW'((addr - BASE_ADDR) >> 3);
    endfunction

    logic [63:0] mem [DEPTH];

    r_state_e    r_state_q, r_state_d;
    logic [3:0]  r_cnt_q, r_cnt_d;
    logic [63:0] raddr_q, raddr_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        r_capture;
    logic [63:0] r_cap_addr;

    w_state_e    w_state_q, w_state_d;
    logic [3:0]  w_cnt_q, w_cnt_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic [63:0] awaddr_q, awaddr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        aw_hs, w_hs, w_commit, mem_we;
    logic [63:0] w_addr, w_data;
    logic [7:0]  w_strb;
    logic [IW-1:0] w_idx;

    always_comb begin
        r_state_d  = r_state_q;
        r_cnt_d    = r_cnt_q;
        raddr_d    = raddr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        r_capture  = 1'b0;
        r_cap_addr = (r_state_q == R_IDLE) ? i_araddr : raddr_q;
        case (r_state_q)
            R_IDLE: begin
                if (i_arvalid) begin
                    raddr_d = i_araddr;
                    r_cnt_d = LAT;
                    if (LAT == 4'd0) begin
                        r_state_d = R_RESP;
                        r_capture = 1'b1;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                r_cnt_d = r_cnt_q - 4'd1;
                if (r_cnt_q <= 4'd1) begin
                    r_state_d = R_RESP;
                    r_capture = 1'b1;
                end
            end
            R_RESP: begin
                if (i_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
        // Memory is sampled before this edge's write lands, so a colliding read sees old data.
        if (r_capture) begin
            if (in_range(r_cap_addr)) begin
                rdata_d = mem[word_idx(r_cap_addr)];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        w_commit  = 1'b0;
        mem_we    = 1'b0;
        aw_hs     = (w_state_q == W_IDLE) && !aw_held_q && i_awvalid;
        w_hs      = (w_state_q == W_IDLE) && !w_held_q && i_wvalid;
        w_addr    = aw_held_q ? awaddr_q : i_awaddr;
        w_data    = w_held_q ? wdata_q : i_wdata;
        w_strb    = w_held_q ? wstrb_q : i_wstrb;
        w_idx     = word_idx(w_addr);
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = i_awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = i_wdata;
                    wstrb_d  = i_wstrb;
                end
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    w_cnt_d = LAT;
                    if (LAT == 4'd0) begin
                        w_state_d = W_RESP;
                        w_commit  = 1'b1;
                    end else begin
                        w_state_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                w_cnt_d = w_cnt_q - 4'd1;
                if (w_cnt_q <= 4'd1) begin
                    w_state_d = W_RESP;
                    w_commit  = 1'b1;
                end
            end
            W_RESP: begin
                if (i_bready) begin
                    w_state_d = W_IDLE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (w_commit) begin
            mem_we  = in_range(w_addr) && !i_rst;
            bresp_d = in_range(w_addr) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            raddr_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            raddr_q   <= raddr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
        end
    end

    // Memory contents survive reset on purpose.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int k = 0; k < 8; k++) begin
                if (w_strb[k]) mem[w_idx][8*k +: 8] <= w_data[8*k +: 8];
            end
        end
    end

    assign o_arready = (r_state_q == R_IDLE) && !i_rst;
    assign o_rvalid  = (r_state_q == R_RESP) && !i_rst;
    assign o_rdata   = i_rst ? 64'd0 : rdata_q;
    assign o_rresp   = i_rst ? 2'd0 : rresp_q;
    assign o_awready = (w_state_q == W_IDLE) && !aw_held_q && !i_rst;
    assign o_wready  = (w_state_q == W_IDLE) && !w_held_q && !i_rst;
    assign o_bvalid  = (w_state_q == W_RESP) && !i_rst;
    assign o_bresp   = i_rst ? 2'd0 : bresp_q;

endmodule

// File: tb/tb_ysyx_22050710_axil_sram.sv
// tb/tb_ysyx_22050710_axil_sram.sv - self-checking bench for the AXI4-Lite SRAM responder
module tb_ysyx_22050710_axil_sram;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;

    logic        i_clk, i_rst;
    logic [63:0] i_araddr, i_awaddr, i_wdata;
    logic        i_arvalid, i_rready, i_awvalid, i_wvalid, i_bready;
    logic [7:0]  i_wstrb;
    logic        o_arready, o_rvalid, o_awready, o_wready, o_bvalid;
    logic [63:0] o_rdata;
    logic [1:0]  o_rresp, o_bresp;

    ysyx_22050710_axil_sram #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_araddr(i_araddr), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rvalid(o_rvalid), .i_rready(i_rready),
        .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: word array plus per-byte "has been written" mask.
    logic [63:0] mm [DEPTH];
    logic [7:0]  mk [DEPTH];

    function automatic bit in_rng(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(DEPTH) * 64'd8);
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'((a - BASE) / 64'd8);
    endfunction

    function automatic logic [63:0] bmask(input logic [7:0] m);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = m[k] ? 8'hFF : 8'h00;
        return r;
    endfunction

    bit          m_rbusy = 0, m_awh = 0, m_wh = 0, m_wbusy = 0;
    longint      m_rdue = 0, m_wdue = 0, mcyc = 0;
    logic [63:0] m_raddr, m_rexp, m_rmask, m_awaddr, m_wdata;
    logic [7:0]  m_wstrb;
    logic [1:0]  m_rresp, m_bresp;

    always @(negedge i_clk) begin : model
        bit e_ar, e_rv, e_aw, e_w, e_bv;
        int ix;
        e_ar = !i_rst && !m_rbusy;
        e_rv = !i_rst && m_rbusy && (mcyc >= m_rdue);
        e_aw = !i_rst && !m_wbusy && !m_awh;
        e_w  = !i_rst && !m_wbusy && !m_wh;
        e_bv = !i_rst && m_wbusy && (mcyc >= m_wdue);
        // Read sees memory as it was before a write landing in the same cycle.
        if (m_rbusy && mcyc == m_rdue) begin
            if (in_rng(m_raddr)) begin
                ix = widx(m_raddr);
                m_rexp = mm[ix]; m_rmask = bmask(mk[ix]); m_rresp = 2'b00;
            end else begin
                m_rexp = '0; m_rmask = '1; m_rresp = 2'b10;
            end
        end
        if (m_wbusy && mcyc == m_wdue) begin
            if (in_rng(m_awaddr)) begin
                ix = widx(m_awaddr);
                for (int k = 0; k < 8; k++) begin
                    if (m_wstrb[k]) begin
                        mm[ix][8*k +: 8] = m_wdata[8*k +: 8];
                        mk[ix][k] = 1'b1;
                    end
                end
                m_bresp = 2'b00;
            end else begin
                m_bresp = 2'b10;
            end
        end
        chk("arready", o_arready, e_ar);
        chk("rvalid", o_rvalid, e_rv);
        chk("awready", o_awready, e_aw);
        chk("wready", o_wready, e_w);
        chk("bvalid", o_bvalid, e_bv);
        if (e_rv) begin
            chk("rdata", o_rdata & m_rmask, m_rexp & m_rmask);
            chk("rresp", o_rresp, m_rresp);
        end
        if (e_bv) chk("bresp", o_bresp, m_bresp);
        if (i_rst) begin
            chk("rst_rdata", o_rdata, 0);
            chk("rst_rresp", o_rresp, 0);
            chk("rst_bresp", o_bresp, 0);
            m_rbusy = 0; m_wbusy = 0; m_awh = 0; m_wh = 0;
        end else begin
            if (e_rv && i_rready) m_rbusy = 0;
            if (i_arvalid && e_ar) begin
                m_rbusy = 1; m_rdue = mcyc + LAT + 1; m_raddr = i_araddr;
            end
            if (e_bv && i_bready) begin
                m_wbusy = 0; m_awh = 0; m_wh = 0;
            end
            if (i_awvalid && e_aw) begin
                m_awh = 1; m_awaddr = i_awaddr;
            end
            if (i_wvalid && e_w) begin
                m_wh = 1; m_wdata = i_wdata; m_wstrb = i_wstrb;
            end
            if (m_awh && m_wh && !m_wbusy) begin
                m_wbusy = 1; m_wdue = mcyc + LAT + 1;
            end
        end
        mcyc++;
    end

    task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                            input int aw_delay, input int w_delay, input int b_hold,
                            output logic [1:0] bresp, output int bv);
        bit aw_done = 0, w_done = 0, done = 0, hs_aw, hs_w, hs_b;
        int cyc = 0;
        bv = 0; bresp = 2'b11;
        i_awaddr = addr; i_wdata = data; i_wstrb = strb;
        i_awvalid = (aw_delay == 0); i_wvalid = (w_delay == 0); i_bready = (b_hold == 0);
        while (!done && cyc < 100) begin
            @(negedge i_clk);
            hs_aw = i_awvalid && o_awready;
            hs_w  = i_wvalid && o_wready;
            hs_b  = o_bvalid && i_bready;
            if (o_bvalid) bv++;
            if (hs_b) bresp = o_bresp;
            @(posedge i_clk); #1;
            cyc++;
            if (hs_aw) begin i_awvalid = 0; aw_done = 1; end
            if (hs_w) begin i_wvalid = 0; w_done = 1; end
            if (hs_b) done = 1;
            if (!aw_done && cyc >= aw_delay) i_awvalid = 1;
            if (!w_done && cyc >= w_delay) i_wvalid = 1;
            i_bready = !done && (bv >= b_hold);
        end
        chk("write_timeout", done, 1);
        i_awvalid = 0; i_wvalid = 0; i_bready = 0;
    endtask

    task automatic do_read(input logic [63:0] addr, input int r_hold,
                           output logic [63:0] data, output logic [1:0] resp, output int lat);
        bit done = 0, hs_ar, hs_r;
        int k = 0, ar_k = -1, rv = 0;
        data = '0; resp = 2'b11; lat = -1;
        i_araddr = addr; i_arvalid = 1; i_rready = (r_hold == 0);
        while (!done && k < 100) begin
            @(negedge i_clk);
            hs_ar = i_arvalid && o_arready;
            if (hs_ar) ar_k = k;
            if (o_rvalid) begin
                if (rv == 0) begin
                    data = o_rdata; resp = o_rresp; lat = k - ar_k;
                end
                rv++;
            end
            hs_r = o_rvalid && i_rready;
            @(posedge i_clk); #1;
            k++;
            if (hs_ar) i_arvalid = 0;
            if (hs_r) done = 1;
            i_rready = !done && (rv >= r_hold);
        end
        chk("read_timeout", done, 1);
        i_arvalid = 0; i_rready = 0;
    endtask

    function automatic logic [63:0] rnd_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return BASE - 64'(8 * $urandom_range(1, 4));
        if (r == 1) return BASE + 64'(DEPTH * 8) + 64'(8 * $urandom_range(0, 3));
        return BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
    endfunction

    initial begin
        logic [63:0] d, d2;
        logic [1:0]  rr, br, rr2, br2;
        int lat, bv, lat2, bv2, rv_seen;
        for (int i = 0; i < DEPTH; i++) begin mm[i] = '0; mk[i] = '0; end
        i_rst = 1; i_araddr = '0; i_arvalid = 0; i_rready = 0;
        i_awaddr = '0; i_awvalid = 0; i_wdata = '0; i_wstrb = '0; i_wvalid = 0; i_bready = 0;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 0;
        @(negedge i_clk);
        chk("post_rst_arready", o_arready, 1);
        chk("post_rst_awready", o_awready, 1);
        chk("post_rst_wready", o_wready, 1);
        @(posedge i_clk); #1;

        // Basic write/read with AW and W together.
        do_write(BASE + 64'h10, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, 0, br, bv);
        chk("basic_bresp", br, 2'b00);
        do_read(BASE + 64'h10, 0, d, rr, lat);
        chk("basic_rdata", d, 64'h1122_3344_5566_7788);
        chk("basic_rresp", rr, 2'b00);
        chk("basic_latency", lat, 3);

        // Partial strobe.
        do_write(BASE + 64'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, 0, 0, br, bv);
        do_read(BASE + 64'h17, 0, d, rr, lat);
        chk("strobe_rdata", d, 64'h1122_3344_AAAA_AAAA);

        // W four cycles ahead of AW, B held off for five cycles.
        do_write(BASE + 64'h20, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 4, 0, 5, br, bv);
        chk("order_bvalid_cycles", bv, 6);
        chk("order_bresp", br, 2'b00);
        do_read(BASE + 64'h20, 2, d, rr, lat);
        chk("order_rdata", d, 64'hDEAD_BEEF_CAFE_F00D);

        // Out of range: below base, and a write whose truncated index would alias word 0.
        do_write(BASE, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 0, 0, 0, br, bv);
        do_read(64'h7FFF_FFF8, 0, d, rr, lat);
        chk("oor_rresp", rr, 2'b10);
        chk("oor_rdata", d, 64'd0);
        do_write(64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 0, br, bv);
        chk("oor_bresp", br, 2'b10);
        do_read(BASE, 0, d, rr, lat);
        chk("oor_no_alias", d, 64'h0F0E_0D0C_0B0A_0908);

        // Reset while a read waits.
        i_araddr = BASE + 64'h10; i_arvalid = 1;
        @(posedge i_clk); #1;
        i_arvalid = 0; i_rst = 1;
        @(posedge i_clk); #1;
        i_rst = 0;
        @(negedge i_clk);
        chk("rst_read_arready", o_arready, 1);
        rv_seen = 0;
        repeat (5) begin
            if (o_rvalid) rv_seen++;
            @(negedge i_clk);
        end
        chk("rst_read_no_rvalid", rv_seen, 0);
        @(posedge i_clk); #1;
        do_read(BASE + 64'h10, 0, d, rr, lat);
        chk("rst_read_data_kept", d, 64'h1122_3344_AAAA_AAAA);

        // Reset before a write commits.
        i_awaddr = BASE + 64'h20; i_wdata = 64'h5555_5555_5555_5555; i_wstrb = 8'hFF;
        i_awvalid = 1; i_wvalid = 1;
        @(posedge i_clk); #1;
        i_awvalid = 0; i_wvalid = 0; i_rst = 1;
        @(posedge i_clk); #1;
        i_rst = 0;
        do_read(BASE + 64'h20, 0, d, rr, lat);
        chk("rst_write_discarded", d, 64'hDEAD_BEEF_CAFE_F00D);

        // Read capture and write commit on the same edge.
        fork
            do_write(BASE + 64'h10, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 0, br, bv);
            do_read(BASE + 64'h10, 0, d, rr, lat);
        join
        chk("collide_old", d, 64'h1122_3344_AAAA_AAAA);
        do_read(BASE + 64'h10, 0, d, rr, lat);
        chk("collide_new", d, 64'h0123_4567_89AB_CDEF);

        // Randomized traffic; every cycle is checked by the model.
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 2))
                0: do_write(rnd_addr(), {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), br, bv);
                1: do_read(rnd_addr(), $urandom_range(0, 3), d, rr, lat);
                default: fork
                    do_write(rnd_addr(), {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), br2, bv2);
                    do_read(rnd_addr(), $urandom_range(0, 3), d2, rr2, lat2);
                join
            endcase
            repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
        end

        @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
